router_1xn_core: RTL and testbench



---
 rtl/router_pkg.sv | 17 +
 rtl/router_if.sv | 24 ++
 rtl/router_fifo_ch.sv | 37 +++
 rtl/router_1xn_core.sv | 136 +++++++++++++
 tb/tb_router_1xn_core.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared FSM states, stats width and header field helpers for the 1xN router.
package router_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_EMPTY, PAYLOAD, PARITY, DROP, CHECK} state_t;
  localparam int STAT_W = 16;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int unsigned hdr_addr(input int unsigned h, input int aw);
    return h & ((32'd1 << aw) - 32'd1);
  endfunction
  function automatic int unsigned hdr_len(input int unsigned h, input int aw);
    return h >> aw;
  endfunction
endpackage

// File: rtl/router_if.sv
// router_if: source, channel-reader and status signals of the 1xN router (stats ports with ROUTER_STATS_EN).
interface router_if #(parameter int DATA_W = 8, parameter int NUM_CH = 3);
  logic pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic busy;
  logic error;
  logic [NUM_CH-1:0] read_enb;
  logic [NUM_CH-1:0] valid_out;
  logic [NUM_CH*DATA_W-1:0] data_out;
  logic [NUM_CH-1:0] soft_reset;
`ifdef ROUTER_STATS_EN
  logic [NUM_CH*16-1:0] pkt_count;
  logic [15:0] drop_count;
  modport master(output pkt_valid, data_in, read_enb,
                 input busy, error, valid_out, data_out, soft_reset, pkt_count, drop_count);
  modport slave(input pkt_valid, data_in, read_enb,
                output busy, error, valid_out, data_out, soft_reset, pkt_count, drop_count);
`else
  modport master(output pkt_valid, data_in, read_enb,
                 input busy, error, valid_out, data_out, soft_reset);
  modport slave(input pkt_valid, data_in, read_enb,
                output busy, error, valid_out, data_out, soft_reset);
`endif
endinterface

// File: rtl/router_fifo_ch.sv
// router_fifo_ch: first-word-fall-through channel FIFO with synchronous flush; head reads 0 when empty.
module router_fifo_ch
  import router_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] data,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);
  localparam int PW = clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign head = empty ? '0 : mem[rp[PW-1:0]];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  always_ff @(posedge clock)
    if (push && !full) mem[wp[PW-1:0]] <= data;
endmodule

// File: rtl/router_1xn_core.sv
// router_1xn_core: 1-to-NUM_CH packet router with parity check and per-channel stall timeout.
// Define ROUTER_STATS_EN to add per-channel packet counters and a drop counter.
module router_1xn_core
  import router_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT = 30
) (
  input logic clock,
  input logic reset,
  router_if.slave bus
);
  localparam int ADDR_W = clog2(NUM_CH) > 1 ? clog2(NUM_CH) : 1;
  localparam int LEN_W = DATA_W - ADDR_W;
  localparam int NSLOT = 1 << ADDR_W;
  localparam int TW = clog2(TIMEOUT + 1);
  state_t state, nstate;
  logic [ADDR_W-1:0] dest, addr, sel;
  logic [LEN_W-1:0] len;
  logic [LEN_W:0] cnt;
  logic [DATA_W-1:0] par;
  logic busy, wr, acc, error;
  logic [NUM_CH-1:0] full, empty, flush, push;
  logic [NSLOT-1:0] full_p, emp_p, fl_p;
  assign addr = ADDR_W'(hdr_addr(32'(bus.data_in), ADDR_W));
  assign len = LEN_W'(hdr_len(32'(bus.data_in), ADDR_W));
  assign acc = bus.pkt_valid && !busy;
  assign push = NUM_CH'(wr ? (NSLOT'(1) << sel) : NSLOT'(0));
  assign bus.busy = busy;
  assign bus.error = error;
  assign bus.soft_reset = flush;
  // Unused address slots look like permanently empty, never-full channels, so out-of-range headers need no special lookup.
  for (genvar i = 0; i < NSLOT; i++) begin : g_pad
    if (i < NUM_CH) begin : g_real
      assign emp_p[i] = empty[i];
      assign full_p[i] = full[i];
      assign fl_p[i] = flush[i];
    end else begin : g_none
      assign emp_p[i] = 1'b1;
      assign full_p[i] = 1'b0;
      assign fl_p[i] = 1'b0;
    end
  end
  always_comb begin
    nstate = state;
    busy = 1'b0;
    wr = 1'b0;
    sel = dest;
    case (state)
      IDLE: begin
        sel = addr;
        if (bus.pkt_valid && !emp_p[addr]) begin
          busy = 1'b1;
          nstate = WAIT_EMPTY;
        end else if (bus.pkt_valid) begin
          wr = {1'b0, addr} < (ADDR_W+1)'(NUM_CH);
          nstate = !wr ? DROP : (len == '0 ? PARITY : PAYLOAD);
        end
      end
      WAIT_EMPTY: begin
        busy = 1'b1;
        if (!bus.pkt_valid || emp_p[addr]) nstate = IDLE;
      end
      PAYLOAD, PARITY: begin
        busy = fl_p[dest] || full_p[dest];
        if (fl_p[dest]) nstate = DROP;
        else if (bus.pkt_valid && !full_p[dest]) begin
          wr = 1'b1;
          nstate = state == PARITY ? CHECK : (cnt == (LEN_W+1)'(2) ? PARITY : PAYLOAD);
        end
      end
      DROP: if (bus.pkt_valid && cnt == (LEN_W+1)'(1)) nstate = IDLE;
      CHECK: begin
        busy = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end
  // cnt counts bytes still owed including parity, so a flush into DROP keeps it unchanged.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      dest <= '0;
      cnt <= '0;
      par <= '0;
      error <= 1'b0;
    end else begin
      state <= nstate;
      if (acc && state == IDLE) begin
        dest <= addr;
        cnt <= {1'b0, len} + 1'b1;
        par <= bus.data_in;
        error <= 1'b0;
      end else if (acc) begin
        cnt <= cnt - 1'b1;
        par <= par ^ bus.data_in;
      end
      if (state == CHECK) error <= |par;
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [TW-1:0] tcnt;
    router_fifo_ch #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clock(clock),
      .reset(reset),
      .push(push[i]),
      .pop(bus.read_enb[i]),
      .flush(flush[i]),
      .data(bus.data_in),
      .full(full[i]),
      .empty(empty[i]),
      .head(bus.data_out[i*DATA_W +: DATA_W])
    );
    assign bus.valid_out[i] = !empty[i];
    assign flush[i] = !empty[i] && tcnt == TW'(TIMEOUT - 1);
    always_ff @(posedge clock or posedge reset)
      if (reset) tcnt <= '0;
      else tcnt <= (empty[i] || bus.read_enb[i] || flush[i]) ? '0 : tcnt + 1'b1;
  end
`ifdef ROUTER_STATS_EN
  logic [STAT_W-1:0] drops;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_stat
    logic [STAT_W-1:0] pc;
    always_ff @(posedge clock or posedge reset)
      if (reset) pc <= '0;
      else if (state == CHECK && dest == ADDR_W'(i) && pc != '1) pc <= pc + 1'b1;
    assign bus.pkt_count[i*STAT_W +: STAT_W] = pc;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) drops <= '0;
    else if (nstate == DROP && state != DROP && drops != '1) drops <= drops + 1'b1;
  assign bus.drop_count = drops;
`endif
endmodule

// File: tb/tb_router_1xn_core.sv
// tb_router_1xn_core: table-driven packets with a per-channel scoreboard plus full, timeout and wait-empty sequences.
module tb_router_1xn_core;
  localparam int NC = 3;
  localparam int DW = 8;
  typedef struct packed {
    logic [7:0] hdr;
    logic bad;
    logic exp_err;
    logic exp_drop;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int failed = 0;
  logic [7:0] q [NC][$];
  logic [7:0] pkt [$];
  vec_t tbl [8];
  always #5 clock = ~clock;
  router_if #(.DATA_W(DW), .NUM_CH(NC)) bus ();
  router_1xn_core #(.DATA_W(DW), .NUM_CH(NC), .FIFO_DEPTH(4), .TIMEOUT(30)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clock)
    if (!reset)
      for (int i = 0; i < NC; i++) begin
        logic [7:0] d;
        d = bus.data_out[i*DW +: DW];
        if (bus.valid_out[i] && bus.read_enb[i]) begin
          if (q[i].size() == 0) begin
            tests++;
            failed++;
            $display("FAIL extra_byte ch%0d: got %0h, expected no byte", i, d);
          end else chk($sformatf("data_ch%0d", i), 32'(d), 32'(q[i].pop_front()));
        end else if (!bus.valid_out[i]) chk($sformatf("idle_zero_ch%0d", i), 32'(d), 32'd0);
      end
  task automatic make_pkt(input logic [7:0] h, input logic bad);
    logic [7:0] x, b;
    x = h;
    pkt = {h};
    for (int k = 0; k < int'(h[7:2]); k++) begin
      b = 8'((k + 1) * 17);
      pkt.push_back(b);
      x ^= b;
    end
    pkt.push_back(bad ? x ^ 8'h01 : x);
  endtask
  task automatic track(input int ch);
    for (int k = 0; k < pkt.size(); k++) q[ch].push_back(pkt[k]);
  endtask
  task automatic send_byte(input logic [7:0] b, output int st);
    st = 0;
    bus.pkt_valid = 1'b1;
    bus.data_in = b;
    @(negedge clock);
    while (bus.busy && st < 200) begin
      st++;
      @(negedge clock);
    end
    if (st >= 200) chk("stall_bound", 32'(st), 32'd0);
    @(posedge clock);
    #1;
  endtask
  task automatic send_range(input int from, input int to, output int s);
    int st;
    s = 0;
    for (int k = from; k <= to; k++) begin
      send_byte(pkt[k], st);
      s += st;
    end
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (bus.valid_out != '0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("drain", 32'(bus.valid_out), 32'd0);
    @(posedge clock);
    #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int st, stalls, c;
    tbl[0] = '{8'h0D, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h0D, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'h03, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{8'h02, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h14, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h1B, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{8'h0E, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{8'h09, 1'b0, 1'b0, 1'b0};
    bus.pkt_valid = 1'b0;
    bus.data_in = '0;
    bus.read_enb = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_soft", 32'(bus.soft_reset), 32'd0);
    chk("rst_data", 32'(bus.data_out), 32'd0);
    reset = 1'b0;
    make_pkt(8'h0D, 1'b0);
    send_range(0, 1, st);
    bus.pkt_valid = 1'b0;
    chk("pre_reset_valid", 32'(bus.valid_out), 32'h2);
    reset = 1'b1;
    #1;
    chk("async_reset_valid", 32'(bus.valid_out), 32'd0);
    chk("async_reset_data", 32'(bus.data_out), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.read_enb = '1;
    for (int v = 0; v < 8; v++) begin
      make_pkt(tbl[v].hdr, tbl[v].bad);
      if (!tbl[v].exp_drop) track(int'(tbl[v].hdr[1:0]));
      send_byte(pkt[0], stalls);
      chk("err_clear", 32'(bus.error), 32'd0);
      send_range(1, pkt.size() - 1, st);
      stalls += st;
      bus.pkt_valid = 1'b0;
      chk("stalls", 32'(stalls), 32'd0);
      @(negedge clock);
      chk("busy_check", 32'(bus.busy), 32'(!tbl[v].exp_drop));
      @(negedge clock);
      chk("error", 32'(bus.error), 32'(tbl[v].exp_err));
      if (tbl[v].exp_drop) chk("drop_nowrite", 32'(bus.valid_out), 32'd0);
      drain();
      for (int i = 0; i < NC; i++) chk("sb_empty", 32'(q[i].size()), 32'd0);
    end
    bus.read_enb = 3'b110;
    make_pkt(8'h18, 1'b0);
    track(0);
    send_range(0, 3, stalls);
    chk("full_nostall", 32'(stalls), 32'd0);
    bus.data_in = pkt[4];
    @(negedge clock);
    chk("full_busy", 32'(bus.busy), 32'd1);
    chk("full_head", 32'(bus.data_out[7:0]), 32'h18);
    chk("full_valid", 32'(bus.valid_out), 32'h1);
    @(posedge clock);
    #1;
    bus.read_enb = 3'b111;
    send_range(4, 7, st);
    bus.pkt_valid = 1'b0;
    drain();
    chk("full_sb", 32'(q[0].size()), 32'd0);
    bus.read_enb = 3'b011;
    make_pkt(8'h12, 1'b0);
    send_range(0, 3, st);
    bus.data_in = pkt[4];
    c = 3;
    do begin
      @(negedge clock);
      c++;
    end while (!bus.soft_reset[2] && c < 100);
    chk("timeout_cycle", 32'(c), 32'd30);
    chk("soft_reset_ch", 32'(bus.soft_reset), 32'h4);
    @(negedge clock);
    chk("flushed_valid", 32'(bus.valid_out[2]), 32'd0);
    chk("soft_reset_pulse", 32'(bus.soft_reset), 32'd0);
    chk("drop_busy", 32'(bus.busy), 32'd0);
    @(posedge clock);
    #1;
    send_byte(pkt[5], st);
    bus.pkt_valid = 1'b0;
    chk("drop_rest_stalls", 32'(st), 32'd0);
    @(negedge clock);
    chk("drop_rest_valid", 32'(bus.valid_out), 32'd0);
    chk("drop_rest_error", 32'(bus.error), 32'd0);
    chk("drop_rest_idle", 32'(bus.busy), 32'd0);
    @(posedge clock);
    #1;
    bus.read_enb = 3'b111;
    make_pkt(8'h02, 1'b0);
    track(2);
    send_range(0, 1, st);
    bus.pkt_valid = 1'b0;
    drain();
    chk("recover_sb", 32'(q[2].size()), 32'd0);
    bus.read_enb = 3'b110;
    make_pkt(8'h04, 1'b0);
    track(0);
    send_range(0, 2, st);
    make_pkt(8'h00, 1'b0);
    track(0);
    bus.data_in = pkt[0];
    repeat (5) @(negedge clock);
    chk("wait_busy", 32'(bus.busy), 32'd1);
    chk("wait_valid", 32'(bus.valid_out), 32'h1);
    @(posedge clock);
    #1;
    bus.read_enb = 3'b111;
    send_byte(pkt[0], st);
    chk("wait_stalls", 32'(st), 32'd4);
    send_byte(pkt[1], st);
    bus.pkt_valid = 1'b0;
    drain();
    chk("wait_sb", 32'(q[0].size()), 32'd0);
    chk("final_error", 32'(bus.error), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
